// File: rtl/mat_store_arbiter.sv
// ----------------------------------------------------------------------------
// mat_store_arbiter
//
// Shares the single matrix-storage access port between four requesters
// (UART writer, random generator, display reader, operator units). Ownership
// is negotiated with a req/gnt/rel handshake and arbitrated round-robin. The
// owner's access strobes, address and write data go straight through to
// storage. Read data is returned on a shared bus, with a one-hot valid strobe
// addressed to the requester that issued the read.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   : an idle watchdog forces a release after TIMEOUT owner cycles
//               with no access, and pulses timeout_flag.
//   undefined : no watchdog logic, and timeout_flag is tied low.
//
// Ports
//   clk, rst       system clock, synchronous active-high reset
//   req[NREQ]      level request per requester
//   rel[NREQ]      release pulse per requester
//   gnt[NREQ]      registered one-hot grant
//   owner_id[2]    index of the current owner (valid while busy)
//   busy           a grant is active or a drain is in progress
//   acc_we/acc_re  per-requester write/read enables
//   acc_addr       flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   acc_wdata      flattened write data, requester i at [i*DATA_W +: DATA_W]
//   mem_*          storage access port
//   rd_data        mem_rdata passed through
//   rd_valid       one-hot read-data strobe, RD_LAT cycles after the read
//   acc_err        one-cycle pulse after a non-owner access attempt
//   timeout_flag   one-cycle pulse on a watchdog-forced release
// ----------------------------------------------------------------------------
module mat_store_arbiter #(
    parameter int NREQ    = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 1
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 1023
`endif
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ-1:0]          rel,
    output logic [NREQ-1:0]          gnt,
    output logic [1:0]               owner_id,
    output logic                     busy,
    input  logic [NREQ-1:0]          acc_we,
    input  logic [NREQ-1:0]          acc_re,
    input  logic [NREQ*ADDR_W-1:0]   acc_addr,
    input  logic [NREQ*DATA_W-1:0]   acc_wdata,
    output logic                     mem_we,
    output logic                     mem_re,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [DATA_W-1:0]        mem_wdata,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [DATA_W-1:0]        rd_data,
    output logic [NREQ-1:0]          rd_valid,
    output logic                     acc_err,
    output logic                     timeout_flag
);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [1:0]      owner_q, owner_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      drain_q, drain_d;
    logic            acc_err_q, acc_err_d;
    logic [NREQ-1:0] rv_q [RD_LAT];

    logic            own_act;
    logic            owner_we;
    logic            owner_re;
    logic            owner_access;
    logic            expire;
    logic            release_now;
    logic            found;
    logic [1:0]      cand;

    // ------------------------------------------------------------------
    // Access path: only the owner reaches storage; write beats read.
    // ------------------------------------------------------------------
    assign own_act      = (state_q == OWN);
    assign owner_we     = acc_we[owner_q];
    assign owner_re     = acc_re[owner_q];
    assign owner_access = owner_we | owner_re;

    assign mem_we    = own_act & owner_we;
    assign mem_re    = own_act & owner_re & ~owner_we;
    assign mem_addr  = own_act ? acc_addr[int'(owner_q)*ADDR_W +: ADDR_W]  : '0;
    assign mem_wdata = own_act ? acc_wdata[int'(owner_q)*DATA_W +: DATA_W] : '0;

    assign rd_data  = mem_rdata;
    assign rd_valid = rv_q[RD_LAT-1];
    assign gnt      = gnt_q;
    assign owner_id = owner_q;
    assign busy     = (state_q != IDLE);
    assign acc_err  = acc_err_q;

    // ------------------------------------------------------------------
    // Idle watchdog
    // ------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            tflag_q;

    always_comb begin
        wd_d   = '0;
        expire = 1'b0;
        if (state_q == OWN && !owner_access) begin
            wd_d   = wd_q + WD_W'(1);
            expire = (wd_d == WD_W'(TIMEOUT));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q    <= '0;
            tflag_q <= 1'b0;
        end else begin
            wd_q    <= wd_d;
            tflag_q <= expire;
        end
    end

    assign timeout_flag = tflag_q;
`else
    assign expire       = 1'b0;
    assign timeout_flag = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Ownership FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        drain_d     = drain_q;
        acc_err_d   = 1'b0;
        release_now = 1'b0;
        found       = 1'b0;
        cand        = '0;

        case (state_q)
            IDLE: begin
                // Round-robin scan starting at the pointer, wrapping mod 4.
                for (int unsigned k = 0; k < 4; k++) begin
                    cand = ptr_q + 2'(k);
                    if (!found && req[cand]) begin
                        found   = 1'b1;
                        owner_d = cand;
                    end
                end
                if (found) begin
                    gnt_d          = '0;
                    gnt_d[owner_d] = 1'b1;
                    state_d        = OWN;
                end
            end

            OWN: begin
                acc_err_d   = |((acc_we | acc_re) & ~gnt_q);
                // A dropped request is handled exactly like a release.
                release_now = rel[owner_q] | ~req[owner_q] | expire;
                if (release_now) begin
                    gnt_d   = '0;
                    drain_d = 2'(RD_LAT - 1);
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                // Hold off re-arbitration until in-flight reads have returned.
                if (drain_q == 2'd0) begin
                    ptr_d   = owner_q + 2'd1;
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end

            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            drain_q   <= '0;
            acc_err_q <= 1'b0;
            for (int unsigned i = 0; i < unsigned'(RD_LAT); i++) begin
                rv_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            drain_q   <= drain_d;
            acc_err_q <= acc_err_d;
            // Read-valid pipeline: tag each issued read with the owner's grant.
            rv_q[0] <= mem_re ? gnt_q : '0;
            for (int unsigned i = 1; i < unsigned'(RD_LAT); i++) begin
                rv_q[i] <= rv_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_mat_store_arbiter.sv
module tb_mat_store_arbiter;

    localparam int RD_LAT = 1;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, rel, acc_we, acc_re;
    logic [3:0]  gnt, rd_valid;
    logic [1:0]  owner_id;
    logic        busy, mem_we, mem_re, acc_err, timeout_flag;
    logic [31:0] acc_addr, acc_wdata;
    logic [7:0]  mem_addr, mem_wdata, mem_rdata, rd_data;

    mat_store_arbiter #(
        .NREQ(4),
        .ADDR_W(8),
        .DATA_W(8),
        .RD_LAT(RD_LAT)
`ifdef ARB_TIMEOUT_EN
        ,
        .TIMEOUT(TO)
`endif
    ) dut (
        .clk(clk), .rst(rst), .req(req), .rel(rel), .gnt(gnt),
        .owner_id(owner_id), .busy(busy), .acc_we(acc_we), .acc_re(acc_re),
        .acc_addr(acc_addr), .acc_wdata(acc_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .rd_data(rd_data), .rd_valid(rd_valid),
        .acc_err(acc_err), .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        req = '0; rel = '0; acc_we = '0; acc_re = '0;
    endtask

    // ------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------
    typedef struct {
        bit         rst;
        logic [3:0] req, rel, we, re;
        bit         chk;
        logic [3:0] gnt;
        bit         busy;
        logic [1:0] oid;
        bit         mwe, mre;
        logic [7:0] maddr, mwd;
        logic [3:0] rdv;
        bit         err;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input logic [3:0] rq, input logic [3:0] rl,
                       input logic [3:0] we, input logic [3:0] re, input bit c,
                       input logic [3:0] g, input bit b, input logic [1:0] o,
                       input bit mw, input bit mr, input logic [7:0] ma,
                       input logic [7:0] md, input logic [3:0] rv, input bit e);
        vec_t v;
        v.rst = r; v.req = rq; v.rel = rl; v.we = we; v.re = re; v.chk = c;
        v.gnt = g; v.busy = b; v.oid = o; v.mwe = mw; v.mre = mr;
        v.maddr = ma; v.mwd = md; v.rdv = rv; v.err = e;
        tbl.push_back(v);
    endtask

    task automatic run_table();
        //   rst req     rel     we      re      chk gnt     busy oid mwe mre maddr  mwd    rdv     err
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 0);
        add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 0);
        add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0100, 1, 2, 0, 0, 8'h30, 8'h3C, 4'b0000, 0);
        add(0, 4'b0100, 4'b0000, 4'b0100, 4'b0100, 1, 4'b0100, 1, 2, 1, 0, 8'h30, 8'h3C, 4'b0000, 0);
        add(0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0100, 1, 2, 0, 0, 8'h30, 8'h3C, 4'b0000, 0);
        add(1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0100, 1, 2, 0, 0, 8'h30, 8'h3C, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 0);
        add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 0);
        add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 1, 4'b0010, 1, 1, 0, 1, 8'h12, 8'h22, 4'b0000, 0);
        add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0010, 1, 1, 0, 0, 8'h12, 8'h22, 4'b0010, 0);
        add(0, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 1, 4'b0010, 1, 1, 0, 1, 8'h12, 8'h22, 4'b0000, 0);
        add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 1, 0, 0, 8'h00, 8'h00, 4'b0010, 0);
        add(0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0);
        add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0010, 1, 1, 0, 0, 8'h12, 8'h22, 4'b0000, 0);
        add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0);
        add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 1, 0, 0, 8'h00, 8'h00, 4'b0000, 0);
        add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0001, 1, 0, 0, 0, 8'h00, 8'h11, 4'b0000, 0);
        add(0, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 1, 4'b0001, 1, 0, 0, 0, 8'h00, 8'h11, 4'b0000, 0);
        add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0001, 1, 0, 0, 0, 8'h00, 8'h11, 4'b0000, 1);
        add(0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0001, 1, 0, 0, 0, 8'h00, 8'h11, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0001, 1, 0, 0, 0, 8'h00, 8'h11, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 1, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 0, 0, 0, 0, 8'h00, 8'h00, 4'b0000, 0);

        acc_addr  = {8'h05, 8'h30, 8'h12, 8'h00};
        acc_wdata = {8'h44, 8'h3C, 8'h22, 8'h11};
        mem_rdata = 8'h5A;
        foreach (tbl[i]) begin
            rst = tbl[i].rst; req = tbl[i].req; rel = tbl[i].rel;
            acc_we = tbl[i].we; acc_re = tbl[i].re;
            #3;
            if (tbl[i].chk) begin
                chk($sformatf("t%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
                chk($sformatf("t%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
                chk($sformatf("t%0d_oid", i), 32'(owner_id), 32'(tbl[i].oid));
                chk($sformatf("t%0d_mwe", i), 32'(mem_we), 32'(tbl[i].mwe));
                chk($sformatf("t%0d_mre", i), 32'(mem_re), 32'(tbl[i].mre));
                chk($sformatf("t%0d_maddr", i), 32'(mem_addr), 32'(tbl[i].maddr));
                chk($sformatf("t%0d_mwd", i), 32'(mem_wdata), 32'(tbl[i].mwd));
                chk($sformatf("t%0d_rdv", i), 32'(rd_valid), 32'(tbl[i].rdv));
                chk($sformatf("t%0d_rdd", i), 32'(rd_data), 32'h5A);
                chk($sformatf("t%0d_err", i), 32'(acc_err), 32'(tbl[i].err));
                chk($sformatf("t%0d_tflag", i), 32'(timeout_flag), 32'h0);
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    // Round robin: all requesting, each owner releases on its 2nd cycle
    // ------------------------------------------------------------------
    task automatic run_rr();
        int order[5];
        int gaps[5];
        int n = 0, held = 0, gap = 0;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b1111;
        for (int c = 0; c < 80 && n < 5; c++) begin
            #3;
            rel = '0;
            if (gnt != 4'b0000) begin
                held++;
                if (held == 1) begin
                    order[n] = -1;
                    for (int k = 0; k < 4; k++) if (gnt == 4'(1 << k)) order[n] = k;
                    gaps[n] = gap;
                    gap = 0;
                    n++;
                end
                if (held == 2) rel = gnt;
            end else begin
                held = 0;
                gap++;
            end
            tick();
        end
        rel = '0;
        chk("rr_grant_count", 32'(n), 32'd5);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 4));
            if (i > 0) chk($sformatf("rr_gap%0d", i), 32'(gaps[i]), 32'(RD_LAT + 1));
        end
    endtask

    // ------------------------------------------------------------------
    // Idle owner: forced revoke with watchdog, indefinite hold without
    // ------------------------------------------------------------------
    task automatic run_idle();
        int got = 0;
        int bad = 0;
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0011;
        for (int c = 0; c < 10 && got == 0; c++) begin
            #3;
            if (gnt != 4'b0000) got = 1;
            else tick();
        end
        chk("idle_first_gnt", 32'(gnt), 32'b0001);
        if (TO_EN) begin
            for (int k = 0; k <= 10; k++) begin
                chk($sformatf("wd_gnt%0d", k), 32'(gnt),
                    (k < TO) ? 32'b0001 : ((k == TO + 2) ? 32'b0010 : 32'b0000));
                chk($sformatf("wd_flag%0d", k), 32'(timeout_flag), 32'(k == TO));
                tick();
                #3;
            end
        end else begin
            for (int k = 0; k < 100; k++) begin
                if (gnt !== 4'b0001 || timeout_flag !== 1'b0) bad++;
                tick();
                #3;
            end
            chk("hold100_bad_cycles", 32'(bad), 32'd0);
        end
        #1;
    endtask

    // ------------------------------------------------------------------
    // Randomized run against a transaction-level reference model
    // ------------------------------------------------------------------
    typedef struct { int due; int id; } rd_t;

    task automatic run_random();
        rd_t rq[$];
        rd_t keep[$];
        bit  m_own = 0;
        int  m_drain = 0, m_ptr = 0, m_last = 0, m_idle = 0, cyc = 0;
        bit  m_err = 0, m_tf = 0, m_known = 0;
        logic [3:0] e_gnt, e_rdv;
        logic [7:0] e_addr, e_wd;
        bit  e_we, e_re;

        for (int c = 0; c < 1500; c++) begin
            rst = (c == 0) || ($urandom % 150 == 0);
            for (int i = 0; i < 4; i++) begin
                req[i]    = ($urandom % 4) != 0;
                rel[i]    = ($urandom % 10) == 0;
                acc_we[i] = ($urandom % 4) == 0;
                acc_re[i] = ($urandom % 4) == 0;
            end
            acc_addr  = $urandom;
            acc_wdata = $urandom;
            mem_rdata = 8'($urandom);
            #3;
            if (m_known) begin
                e_gnt = m_own ? 4'(1 << m_last) : 4'b0000;
                e_rdv = '0;
                foreach (rq[j]) if (rq[j].due == cyc) e_rdv[rq[j].id] = 1'b1;
                e_we = m_own && acc_we[m_last];
                e_re = m_own && acc_re[m_last] && !acc_we[m_last];
                e_addr = m_own ? acc_addr[m_last*8 +: 8]  : 8'h00;
                e_wd   = m_own ? acc_wdata[m_last*8 +: 8] : 8'h00;
                chk($sformatf("r%0d_gnt", c), 32'(gnt), 32'(e_gnt));
                chk($sformatf("r%0d_busy", c), 32'(busy), 32'(m_own || m_drain > 0));
                chk($sformatf("r%0d_oid", c), 32'(owner_id), 32'(m_last));
                chk($sformatf("r%0d_mwe", c), 32'(mem_we), 32'(e_we));
                chk($sformatf("r%0d_mre", c), 32'(mem_re), 32'(e_re));
                chk($sformatf("r%0d_maddr", c), 32'(mem_addr), 32'(e_addr));
                chk($sformatf("r%0d_mwd", c), 32'(mem_wdata), 32'(e_wd));
                chk($sformatf("r%0d_rdv", c), 32'(rd_valid), 32'(e_rdv));
                chk($sformatf("r%0d_rdd", c), 32'(rd_data), 32'(mem_rdata));
                chk($sformatf("r%0d_err", c), 32'(acc_err), 32'(m_err));
                chk($sformatf("r%0d_tflag", c), 32'(timeout_flag), 32'(m_tf));
            end
            // advance the model with the inputs seen at this edge
            if (rst) begin
                m_known = 1; m_own = 0; m_drain = 0; m_ptr = 0; m_last = 0;
                m_idle = 0; m_err = 0; m_tf = 0;
                rq.delete();
            end else begin
                bit acc, expire;
                m_err = 0;
                m_tf  = 0;
                keep.delete();
                foreach (rq[j]) if (rq[j].due > cyc) keep.push_back(rq[j]);
                rq = keep;
                if (m_own) begin
                    acc = acc_we[m_last] || acc_re[m_last];
                    if (acc_re[m_last] && !acc_we[m_last]) rq.push_back('{cyc + RD_LAT, m_last});
                    m_err  = ((acc_we | acc_re) & ~(4'(1 << m_last))) != 4'b0000;
                    expire = TO_EN && !acc && (m_idle + 1 >= TO);
                    m_idle = acc ? 0 : m_idle + 1;
                    if (rel[m_last] || !req[m_last] || expire) begin
                        m_own   = 0;
                        m_drain = RD_LAT;
                        m_tf    = expire;
                    end
                end else if (m_drain > 0) begin
                    m_drain--;
                    if (m_drain == 0) m_ptr = (m_last + 1) % 4;
                end else begin
                    for (int k = 0; k < 4 && !m_own; k++) begin
                        if (req[(m_ptr + k) % 4]) begin
                            m_last = (m_ptr + k) % 4;
                            m_own  = 1;
                            m_idle = 0;
                        end
                    end
                end
            end
            cyc++;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        acc_addr = '0; acc_wdata = '0; mem_rdata = '0;
        run_table();
        run_rr();
        run_idle();
        run_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mat_store_arbiter.md
Name: mat_store_arbiter

Overview:
- Shares the single matrix-storage access port between four requesters: UART input writer, random generator, display reader, and operator units (add/transpose/scalar/matmul).
- Requesters use a req/gnt/rel handshake. The current owner's address, write-enable and data are forwarded to storage, and read data is returned with a valid strobe.
- Round-robin arbitration with an idle-watchdog revoke. Sits between the main control FSM and the storage block.

Parameters:
- NREQ, 4, number of requesters. Fixed at 4; owner_id is 2 bits.
- ADDR_W, 8, storage address width: {slot[0], row[2:0], col[2:0], pad}.
- DATA_W, 8, element width.
- RD_LAT, 1, storage read latency in cycles (1..3).
- TIMEOUT, 1023, idle cycles an owner may hold the grant before a forced revoke.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  level request, one bit per requester.
- rel  in  NREQ  release pulse, one bit per requester.
- gnt  out  NREQ  one-hot grant, registered.
- owner_id  out  2  index of current owner; valid while busy.
- busy  out  1  a grant is active or a drain is in progress.
- acc_we  in  NREQ  per-requester write enable.
- acc_re  in  NREQ  per-requester read enable.
- acc_addr  in  NREQ*ADDR_W  flattened addresses; requester i occupies [i*ADDR_W +: ADDR_W].
- acc_wdata  in  NREQ*DATA_W  flattened write data.
- mem_we  out  1  to storage.
- mem_re  out  1  to storage.
- mem_addr  out  ADDR_W  to storage.
- mem_wdata  out  DATA_W  to storage.
- mem_rdata  in  DATA_W  from storage.
- rd_data  out  DATA_W  mem_rdata passed through; shared by all requesters.
- rd_valid  out  NREQ  one-hot read-data strobe to the issuing requester.
- acc_err  out  1  one-cycle pulse: access attempted by a non-owner.
- timeout_flag  out  1  one-cycle pulse on forced revoke.

Behaviour:
- Reset (rst=1 at a clk edge) clears all outputs to 0: gnt, owner_id, busy, rd_valid, acc_err, timeout_flag. It also clears the read-valid pipeline and the watchdog, and sets the round-robin pointer to 0. A reset mid-operation drops any grant at that edge, and in-flight reads are discarded.
- States: IDLE, OWN, DRAIN.
- IDLE: if req != 0, pick the first set bit scanning from the pointer upward with wrap (pointer, pointer+1, ... mod 4). At the next edge: gnt one-hot, owner_id set, busy=1, state OWN. Grant latency is 1 cycle from req sampled high.
- OWN, access path:
  - mem_we = acc_we[owner] and mem_re = acc_re[owner], both combinational from the owner's inputs while gnt is high.
  - mem_addr and mem_wdata are muxed from the owner's slice.
  - If acc_we and acc_re are both high in the same cycle, write wins and no read is issued.
- OWN, read return: for each issued read, rd_valid[owner] pulses exactly RD_LAT cycles later, with rd_data = mem_rdata.
- OWN, non-owner accesses: acc_we or acc_re from a non-owner is ignored (no mem strobe) and acc_err pulses the next cycle.
- OWN, release: rel[owner] high at an edge causes gnt to go 0 next cycle and the state moves to DRAIN. rel from non-owners is ignored. An owner access in the same cycle as its rel is still performed.
- OWN, request drop: req[owner] falling without rel is treated as a release.
- DRAIN: lasts RD_LAT cycles so outstanding rd_valid strobes still complete. busy stays 1 and gnt=0. Then the pointer becomes owner+1 mod 4 and the state returns to IDLE. Re-arbitration happens in IDLE the cycle after, so back-to-back grants have a gap of RD_LAT+1 cycles.
- Fairness: a requester that is continuously requesting is granted within 3 other ownerships.
- Watchdog: counts OWN cycles with no owner access and resets on any owner access. When the count reaches TIMEOUT, the arbiter performs a forced release (same path as rel) and timeout_flag pulses.

Optional Feature:
- ARB_TIMEOUT_EN defined: watchdog active as above.
- Not defined: no watchdog counter is synthesized and timeout_flag is tied to 0. An owner holds the grant indefinitely until rel or req drops.

Test Plan:
- Reset then req=4'b0100 → gnt=4'b0100 one cycle later, owner_id=2, busy=1. Reset asserted during OWN → gnt=0, busy=0 at that edge.
- req=4'b1111 held, each owner pulses rel after 2 cycles → grant order 0,1,2,3,0. Gap between grants is 2 cycles (RD_LAT=1).
- Owner 1 reads addr 0x12 with mem_rdata=0x5A → mem_re=1 that cycle. Next cycle: rd_valid=4'b0010, rd_data=0x5A. A read issued in the same cycle as rel still yields rd_valid during DRAIN.
- Owner 0 granted; requester 3 asserts acc_we with addr 0x05 → mem_we=0 and acc_err pulses once.
- With ARB_TIMEOUT_EN and TIMEOUT=8: owner idle for 8 cycles → timeout_flag pulses, gnt drops, and the next requester is granted. Without the macro: grant held for 100 idle cycles.
- Owner 2 asserts acc_we and acc_re together with wdata=0x3C → mem_we=1, mem_re=0, no rd_valid.
